regfile_mp: RTL

//  Parametrised multi-read-port register file with write-to-read bypass, per-register

---
 rtl/regfile_mp.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// Multi-read-port register file with write bypass, pending bits and a sequential soft clear.
// Optional debug ports (dbg_readReg, dbg_data, dbg_wr_count) are enabled by defining REGFILE_DBG_EN.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                    clock,
  input  logic                    ctrl_reset_n,
  input  logic                    ctrl_writeEnable,
  input  logic [ADDR_W-1:0]       ctrl_writeReg,
  input  logic [DATA_W-1:0]       data_writeReg,
  input  logic [NREAD*ADDR_W-1:0] ctrl_readReg,
  output logic [NREAD*DATA_W-1:0] data_readReg,
  output logic [NREAD-1:0]        pend_readReg,
  input  logic                    ctrl_reserveEnable,
  input  logic [ADDR_W-1:0]       ctrl_reserveReg,
  input  logic                    ctrl_clear,
  output logic                    ctrl_busy,
  output logic                    err_wr_drop
`ifdef REGFILE_DBG_EN
  ,
  input  logic [ADDR_W-1:0]       dbg_readReg,
  output logic [DATA_W-1:0]       dbg_data,
  output logic [15:0]             dbg_wr_count
`endif
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  pend_q;
  logic              err_q;

  logic idle_s;
  logic wr_commit_s;
  logic rsv_s;
  logic enter_clear_s;

  // Entry 0 is hard-wired to zero only when ZERO_REG is set.
  function automatic logic is_prot(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG != 0) && (addr == {ADDR_W{1'b0}});
  endfunction

  assign idle_s        = (state_q == ST_IDLE);
  assign wr_commit_s   = ctrl_writeEnable && idle_s && !is_prot(ctrl_writeReg);
  assign rsv_s         = ctrl_reserveEnable && idle_s && !is_prot(ctrl_reserveReg);
  assign enter_clear_s = idle_s && ctrl_clear;

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state_q <= ST_IDLE;
      idx_q   <= {ADDR_W{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= ctrl_writeEnable && (state_q == ST_CLEAR);
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_clear) begin
          state_d = ST_CLEAR;
          idx_d   = {ADDR_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        // Index naturally wraps to 0 as the last entry is zeroed.
        idx_d = idx_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        if (idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = {ADDR_W{1'b0}};
      end
    endcase
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
    end else if (state_q == ST_CLEAR) begin
      mem_q[idx_q] <= {DATA_W{1'b0}};
    end else if (wr_commit_s) begin
      mem_q[ctrl_writeReg] <= data_writeReg;
    end
  end

  // Reserve is applied after the write clear so a new producer wins on a collision.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      pend_q <= {DEPTH{1'b0}};
    end else if (enter_clear_s) begin
      pend_q <= {DEPTH{1'b0}};
    end else begin
      if (wr_commit_s) begin
        pend_q[ctrl_writeReg] <= 1'b0;
      end
      if (rsv_s) begin
        pend_q[ctrl_reserveReg] <= 1'b1;
      end
    end
  end

  // Bypass is gated by reset so outputs collapse to zero as soon as reset asserts.
  always_comb begin
    data_readReg = {(NREAD*DATA_W){1'b0}};
    pend_readReg = {NREAD{1'b0}};
    for (int k = 0; k < NREAD; k++) begin
      logic [ADDR_W-1:0] ra;
      ra = ctrl_readReg[k*ADDR_W +: ADDR_W];
      if (is_prot(ra)) begin
        data_readReg[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
      end else if (wr_commit_s && ctrl_reset_n && (ra == ctrl_writeReg)) begin
        data_readReg[k*DATA_W +: DATA_W] = data_writeReg;
      end else begin
        data_readReg[k*DATA_W +: DATA_W] = mem_q[ra];
      end
      pend_readReg[k] = pend_q[ra];
    end
  end

  assign ctrl_busy   = (state_q == ST_CLEAR);
  assign err_wr_drop = err_q;

`ifdef REGFILE_DBG_EN
  logic [15:0] dbg_cnt_q;

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      dbg_cnt_q <= 16'd0;
    end else if (wr_commit_s) begin
      dbg_cnt_q <= dbg_cnt_q + 16'd1;
    end else begin
      dbg_cnt_q <= dbg_cnt_q;
    end
  end

  assign dbg_data     = mem_q[dbg_readReg];
  assign dbg_wr_count = dbg_cnt_q;
`endif

endmodule
